// File: rtl/fsm_lockstep_sequencer.sv
// Lockstep replay sequencer: drives a stored pattern onto w of two FSM encodings and cross-checks their z outputs.
// Optional SEQ_LOOP_EN: restart from CLEAR after the last step forever instead of stopping in DONE.
module fsm_lockstep_sequencer #(
  parameter int unsigned PAT_W    = 16,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic             z_a,
  input  logic             z_b,
  output logic             w_out,
  output logic             fsm_step,
  output logic             fsm_clr,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic [4:0]       first_err_idx
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned PH_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_STEP  = PH_W'(STEP_DIV - 2);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, DRIVE, SAMPLE, DONE} stateT;

  stateT            state, stateNext;
  logic [PH_W-1:0]  phase, phaseNext;
  logic [IDX_W-1:0] idx, idxNext;
  logic [31:0]      patReg, patNext;
  logic [7:0]       errNext;
  logic             misNext;
  logic [4:0]       firstNext;
  logic             wNext, stepNext, clrNext, busyNext, doneNext;

  // State, counters, results and all outputs are registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      idx           <= '0;
      patReg        <= '0;
      w_out         <= 1'b0;
      fsm_step      <= 1'b0;
      fsm_clr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      state         <= stateNext;
      phase         <= phaseNext;
      idx           <= idxNext;
      patReg        <= patNext;
      w_out         <= wNext;
      fsm_step      <= stepNext;
      fsm_clr       <= clrNext;
      busy          <= busyNext;
      done          <= doneNext;
      mismatch      <= misNext;
      err_count     <= errNext;
      first_err_idx <= firstNext;
    end
  end

  // Next state, counters and results; outputs are decoded from the next state
  always_comb begin
    stateNext = state;
    phaseNext = phase;
    idxNext   = idx;
    patNext   = patReg;
    errNext   = err_count;
    misNext   = mismatch;
    firstNext = first_err_idx;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext = CLEAR;
          phaseNext = '0;
          idxNext   = '0;
          patNext   = 32'(pattern);
          errNext   = '0;
          misNext   = 1'b0;
          firstNext = '0;
        end
      end
      CLEAR: begin
        if (abort) begin
          stateNext = IDLE;
          phaseNext = '0;
        end else if (phase == PH_ONE) begin
          stateNext = DRIVE;
          phaseNext = '0;
          idxNext   = '0;
        end else begin
          phaseNext = phase + PH_ONE;
        end
      end
      DRIVE: begin
        if (abort) begin
          stateNext = IDLE;
          phaseNext = '0;
        end else if (phase == PH_STEP) begin
          stateNext = SAMPLE;
          phaseNext = '0;
        end else begin
          phaseNext = phase + PH_ONE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          stateNext = IDLE;
          phaseNext = '0;
        end else begin
          if (z_a != z_b) begin
            if (err_count != 8'hFF) errNext = err_count + 8'd1;
            misNext = 1'b1;
            if (!mismatch) firstNext = idx;
          end
          if (idx == IDX_LAST) begin
`ifdef SEQ_LOOP_EN
            stateNext = CLEAR;
            idxNext   = '0;
`else
            stateNext = DONE;
`endif
          end else begin
            stateNext = DRIVE;
            idxNext   = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        phaseNext = '0;
      end
    endcase

    busyNext = (stateNext == CLEAR) || (stateNext == DRIVE) || (stateNext == SAMPLE);
    clrNext  = (stateNext == CLEAR);
    doneNext = (stateNext == DONE);
    stepNext = (stateNext == DRIVE) && (phaseNext == PH_STEP);
    wNext    = ((stateNext == DRIVE) || (stateNext == SAMPLE)) ? patNext[idxNext] : 1'b0;
  end

endmodule

// File: tb/tb_fsm_lockstep_sequencer.sv
// Bench for fsm_lockstep_sequencer: cycle-offset reference model plus directed run scenarios.
module tb_fsm_lockstep_sequencer;

  localparam int PAT_W = 16;
  localparam int SD    = 4;
  localparam int RUN   = 2 + PAT_W * SD;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [PAT_W-1:0] pattern;
  logic             zA, zB;
  logic             w_out, fsm_step, fsm_clr, busy, done, mismatch;
  logic [7:0]       err_count;
  logic [4:0]       first_err_idx;

  int          cmpCnt  = 0;
  int          failCnt = 0;
  logic [31:0] injMask = '0;

  always #5 clk = ~clk;

  fsm_lockstep_sequencer #(.PAT_W(PAT_W), .STEP_DIV(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .z_a(zA), .z_b(zB), .w_out(w_out), .fsm_step(fsm_step), .fsm_clr(fsm_clr),
    .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  task automatic check(input string name, input int act, input int exp);
    cmpCnt++;
    if (act != exp) begin
      failCnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is just a cycle offset mT counted from the accepted start edge
  bit          mActive = 0;
  bit          mDone   = 0;
  bit          mMis    = 0;
  int          mT      = 0;
  int          mErr    = 0;
  int          mFirst  = 0;
  logic [31:0] mPat    = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mActive <= 0; mDone <= 0; mMis <= 0; mT <= 0; mErr <= 0; mFirst <= 0; mPat <= '0;
    end else if (!mActive) begin
      if (start) begin
        mActive <= 1; mT <= 0; mDone <= 0; mMis <= 0; mErr <= 0; mFirst <= 0;
        mPat <= 32'(pattern);
      end
    end else if (abort) begin
      mActive <= 0;
    end else begin
      if (mT >= 2 && (mT - 2) % SD == SD - 1 && zA != zB) begin
        if (mErr < 255) mErr <= mErr + 1;
        if (!mMis) mFirst <= (mT - 2) / SD;
        mMis <= 1;
      end
      if (mT == RUN - 1) begin
`ifdef SEQ_LOOP_EN
        mT <= 0;
`else
        mActive <= 0;
        mDone   <= 1;
`endif
      end else begin
        mT <= mT + 1;
      end
    end
  end

  logic expW, expStep, expClr, expBusy, expDone;
  always_comb begin
    expW = 1'b0; expStep = 1'b0; expClr = 1'b0; expBusy = 1'b0; expDone = mDone;
    if (mActive) begin
      expBusy = 1'b1;
      expDone = 1'b0;
      expClr  = (mT < 2);
      if (mT >= 2) begin
        expW    = mPat[(mT - 2) / SD];
        expStep = ((mT - 2) % SD == SD - 2);
      end
    end
  end

  // z stimulus: random z_a, z_b inverted for whole steps selected by injMask
  always @(negedge clk) begin
    zA = 1'($urandom_range(0, 1));
    zB = zA ^ ((mActive && mT >= 2) ? injMask[(mT - 2) / SD] : 1'b0);
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_w_out",    int'(w_out),         int'(expW));
    check("cyc_fsm_step", int'(fsm_step),      int'(expStep));
    check("cyc_fsm_clr",  int'(fsm_clr),       int'(expClr));
    check("cyc_busy",     int'(busy),          int'(expBusy));
    check("cyc_done",     int'(done),          int'(expDone));
    check("cyc_mismatch", int'(mismatch),      int'(mMis));
    check("cyc_err",      int'(err_count),     mErr);
    check("cyc_first",    int'(first_err_idx), mMis ? mFirst : int'(first_err_idx));
  end

  task automatic startRun();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Observe a run from t=0 (first negedge after the start edge) until done or maxT
  task automatic collect(input int maxT, input int startAt, output int doneAt,
                         output int stepCnt, output int firstStep, output int badSpacing,
                         output int clrCnt, output logic [31:0] wAtStep);
    int lastStep;
    lastStep = -1; doneAt = -1; stepCnt = 0; firstStep = -1; badSpacing = 0; clrCnt = 0;
    wAtStep = '0;
    for (int t = 0; t < maxT && doneAt < 0; t++) begin
      if (t > 0) @(negedge clk);
      start = (t == startAt);
      if (fsm_step) begin
        if (stepCnt < 32) wAtStep[stepCnt] = w_out;
        if (lastStep >= 0 && t - lastStep != SD) badSpacing++;
        if (lastStep < 0) firstStep = t;
        lastStep = t;
        stepCnt++;
      end
      if (fsm_clr) clrCnt++;
      if (done) doneAt = t;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneAt, stepCnt, firstStep, badSpacing, clrCnt;
    logic [31:0] wAtStep;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_err",  int'(err_count), 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SEQ_LOOP_EN
    begin
      int clrRise, doneSeen;
      logic prevClr;
      clrRise = 0; doneSeen = 0; prevClr = 1'b0;
      pattern = 16'hFFFF; injMask = 32'h1;
      startRun();
      for (int t = 0; t < 3 * RUN; t++) begin
        if (t > 0) @(negedge clk);
        if (fsm_clr && !prevClr) clrRise++;
        prevClr = fsm_clr;
        if (done) doneSeen++;
      end
      check("loop_clr_pulses", clrRise, 3);
      check("loop_done_seen",  doneSeen, 0);
      check("loop_err",        int'(err_count), 3);
      check("loop_first",      int'(first_err_idx), 0);
      check("loop_mismatch",   int'(mismatch), 1);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("loop_abort_busy", int'(busy), 0);
      check("loop_abort_done", int'(done), 0);
    end
`else
    // Clean run
    pattern = 16'hFFFF; injMask = '0;
    startRun();
    collect(RUN + 20, -1, doneAt, stepCnt, firstStep, badSpacing, clrCnt, wAtStep);
    check("clean_done_at",    doneAt, 66);
    check("clean_steps",      stepCnt, 16);
    check("clean_first_step", firstStep, 4);
    check("clean_spacing",    badSpacing, 0);
    check("clean_clr_cycles", clrCnt, 2);
    check("clean_w",          int'(wAtStep[15:0]), 32'hFFFF);
    check("clean_err",        int'(err_count), 0);
    check("clean_mismatch",   int'(mismatch), 0);

    // Injected divergence at steps 3 and 7
    pattern = 16'hA5C3; injMask = 32'h88;
    startRun();
    collect(RUN + 20, -1, doneAt, stepCnt, firstStep, badSpacing, clrCnt, wAtStep);
    check("inj_done_at",  doneAt, 66);
    check("inj_err",      int'(err_count), 2);
    check("inj_first",    int'(first_err_idx), 3);
    check("inj_mismatch", int'(mismatch), 1);
    check("inj_w",        int'(wAtStep[15:0]), 32'hA5C3);

    // Stimulus order, with a stray start pulse during DRIVE of step 2
    pattern = 16'h0005; injMask = '0;
    startRun();
    collect(RUN + 20, 10, doneAt, stepCnt, firstStep, badSpacing, clrCnt, wAtStep);
    check("order_w_0to3",  int'(wAtStep[3:0]), 5);
    check("order_done_at", doneAt, 66);
    check("order_steps",   stepCnt, 16);
    check("order_spacing", badSpacing, 0);

    // Abort in DRIVE of step 5 with a mismatch at step 2
    pattern = 16'h1234; injMask = 32'h4;
    startRun();
    repeat (22) @(negedge clk);
    check("abort_pre_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy",     int'(busy), 0);
    check("abort_done",     int'(done), 0);
    check("abort_step",     int'(fsm_step), 0);
    check("abort_clr",      int'(fsm_clr), 0);
    check("abort_err",      int'(err_count), 1);
    check("abort_first",    int'(first_err_idx), 2);
    check("abort_mismatch", int'(mismatch), 1);
    repeat (10) @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);
    check("abort_err_held",   int'(err_count), 1);

    // Reset during SAMPLE of step 9, then a full run
    pattern = 16'hFFFF; injMask = 32'h10;
    startRun();
    repeat (41) @(negedge clk);
    check("rstmid_pre_mismatch", int'(mismatch), 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_w",        int'(w_out), 0);
    check("rstmid_step",     int'(fsm_step), 0);
    check("rstmid_clr",      int'(fsm_clr), 0);
    check("rstmid_busy",     int'(busy), 0);
    check("rstmid_done",     int'(done), 0);
    check("rstmid_mismatch", int'(mismatch), 0);
    check("rstmid_err",      int'(err_count), 0);
    check("rstmid_first",    int'(first_err_idx), 0);
    @(negedge clk) reset = 1'b1;
    injMask = '0;
    startRun();
    collect(RUN + 20, -1, doneAt, stepCnt, firstStep, badSpacing, clrCnt, wAtStep);
    check("rstmid_rerun_done_at", doneAt, 66);
    check("rstmid_rerun_err",     int'(err_count), 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", cmpCnt, failCnt);
    $finish;
  end

endmodule
